// File: rtl/slsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, memory size codes,
// the FSM state type and the request legality checks.
package slsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } lsu_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return (size == MEM_SIZE_HALF && lsb[0]) ||
               (size == MEM_SIZE_WORD && lsb != 2'b00);
    endfunction

endpackage

// File: rtl/slsu_ldext.sv
// Combinational load-data extension selected by the RV32I load funct3.
module slsu_ldext
    import slsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){rdata[7]}}, rdata[7:0]};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, rdata[7:0]};
            F3_H:    data = {{(DATA_WIDTH-16){rdata[15]}}, rdata[15:0]};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/slsu.sv
// Single-outstanding load/store unit: validates a request, issues a one-cycle
// access to the data memory and returns an extended load result or error.
module slsu
    import slsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_size_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  rsp_is_load_o,
    output logic                  rsp_err_o
);

    // Same bound the memory applies, regardless of access size.
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_SIZE - 3);

    lsu_state_e            state;
    lsu_state_e            state_next;
    logic                  accept;
    logic                  req_err;
    logic                  we;
    logic                  err;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [4:0]            rd;
    logic                  access;
    logic [DATA_WIDTH-1:0] ld_data;

    assign accept  = (state == IDLE) && req_valid_i;
    assign req_err = f3_illegal(req_we_i, req_funct3_i) ||
                     misaligned(req_funct3_i[1:0], req_addr_i[1:0]) ||
                     (req_addr_i >= ADDR_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_i) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we     <= 1'b0;
            err    <= 1'b0;
            funct3 <= '0;
            addr   <= '0;
            wdata  <= '0;
            rd     <= '0;
        end else if (accept) begin
            we     <= req_we_i;
            err    <= req_err;
            funct3 <= req_funct3_i;
            addr   <= req_addr_i;
            wdata  <= req_wdata_i;
            rd     <= req_rd_i;
        end
    end

    // Strobes are decoded from state so an async reset drops them at once.
    assign access      = (state == ACCESS) && !err;
    assign mem_read_o  = access && !we;
    assign mem_write_o = access && we;
    assign mem_size_o  = access ? funct3[1:0] : '0;
    assign mem_addr_o  = access ? addr : '0;
    assign mem_wdata_o = access ? wdata : '0;

    slsu_ldext #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ldext (
        .funct3(funct3),
        .rdata (mem_rdata_i),
        .data  (ld_data)
    );

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_o   <= '0;
            rsp_rd_o      <= '0;
            rsp_is_load_o <= 1'b0;
            rsp_err_o     <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_rdata_o   <= (we || err) ? '0 : ld_data;
            rsp_rd_o      <= we ? '0 : rd;
            rsp_is_load_o <= !we;
            rsp_err_o     <= err;
        end
    end

endmodule

// File: tb/tb_slsu.sv
// Self-checking bench for slsu: byte-array memory model on the DUT side and an
// independent byte-array scoreboard computing expected responses from the ISA rules.
module tb_slsu;

    localparam int DW  = 32;
    localparam int MSZ = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [DW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [4:0]    req_rd = '0;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_size;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [4:0]    rsp_rd;
    logic          rsp_is_load;
    logic          rsp_err;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    logic [7:0] mem     [MSZ];
    logic [7:0] ref_mem [MSZ];
    logic       mem_inited = 1'b0;

    always #5 clk = ~clk;

    slsu #(
        .DATA_WIDTH(DW),
        .MEM_SIZE  (MSZ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_rd_i     (req_rd),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_size_o   (mem_size),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_rd_o     (rsp_rd),
        .rsp_is_load_o(rsp_is_load),
        .rsp_err_o    (rsp_err)
    );

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 53 + 7) ^ (i >> 3));
    endfunction

    // Data memory: combinational sign-extending read, write on the clock edge.
    always_comb begin
        mem_rdata = '0;
        if (mem_read && mem_addr < MSZ - 3) begin
            case (mem_size)
                2'b00:   mem_rdata = {{24{mem[int'(mem_addr)][7]}}, mem[int'(mem_addr)]};
                2'b01:   mem_rdata = {{16{mem[int'(mem_addr)+1][7]}}, mem[int'(mem_addr)+1],
                                      mem[int'(mem_addr)]};
                default: mem_rdata = {mem[int'(mem_addr)+3], mem[int'(mem_addr)+2],
                                      mem[int'(mem_addr)+1], mem[int'(mem_addr)]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= seed_byte(i);
            mem_inited <= 1'b1;
        end else if (mem_write && mem_addr < MSZ - 3) begin
            mem[int'(mem_addr)] <= mem_wdata[7:0];
            if (mem_size != 2'b00) mem[int'(mem_addr)+1] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[int'(mem_addr)+2] <= mem_wdata[23:16];
                mem[int'(mem_addr)+3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_read)  rd_pulses <= rd_pulses + 1;
        if (mem_write) wr_pulses <= wr_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left on a falling edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int hold,
                          output logic [31:0] got);
        int          n;
        logic        e;
        logic [31:0] exp_d;
        logic [31:0] v;
        int          rp0;
        int          wp0;
        bit          ok;
        n = 1 << f3[1:0];
        e = (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) ||
            (a % n != 0) || (a >= MSZ - 3);
        exp_d = '0;
        if (!e && !we) begin
            v = '0;
            for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(a) + i]) << (8 * i);
            if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
            exp_d = v;
        end
        if (!e && we)
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        rp0 = rd_pulses;
        wp0 = wr_pulses;
        got = '0;

        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_ready", 32'(ok), 32'd1);
        if (!ok) return;

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        @(negedge clk);
        chk("acc_read",   32'(mem_read),  32'(!e && !we));
        chk("acc_write",  32'(mem_write), 32'(!e && we));
        chk("acc_addr",   mem_addr,       e ? 32'd0 : a);
        chk("acc_size",   32'(mem_size),  e ? 32'd0 : 32'(f3[1:0]));
        chk("acc_wdata",  mem_wdata,      e ? 32'd0 : wd);
        chk("acc_rspv",   32'(rsp_valid), 32'd0);
        chk("acc_ready",  32'(req_ready), 32'd0);

        // A competing request outside IDLE must be ignored.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = $urandom;

        @(negedge clk);
        chk("rsp_valid",  32'(rsp_valid),   32'd1);
        chk("rsp_err",    32'(rsp_err),     32'(e));
        chk("rsp_rdata",  rsp_rdata,        exp_d);
        chk("rsp_rd",     32'(rsp_rd),      we ? 32'd0 : 32'(rd));
        chk("rsp_isload", 32'(rsp_is_load), 32'(!we));
        chk("rsp_nostb",  32'(mem_read | mem_write), 32'd0);
        got = rsp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata,      exp_d);
            chk("hold_err",   32'(rsp_err),   32'(e));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rspv",  32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("rd_pulses",  32'(rd_pulses - rp0), 32'(!e && !we));
        chk("wr_pulses",  32'(wr_pulses - wp0), 32'(!e && we));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    logic [31:0] got;
    logic [2:0]  lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        for (int i = 0; i < MSZ; i++) ref_mem[i] = seed_byte(i);

        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(req_ready),   32'd1);
        chk("rst_rspv",   32'(rsp_valid),   32'd0);
        chk("rst_rdata",  rsp_rdata,        32'd0);
        chk("rst_rd",     32'(rsp_rd),      32'd0);
        chk("rst_isload", 32'(rsp_is_load), 32'd0);
        chk("rst_err",    32'(rsp_err),     32'd0);
        chk("rst_mem",    {mem_read, mem_write, mem_size}, 32'd0);
        chk("rst_maddr",  mem_addr,         32'd0);
        chk("rst_mwdata", mem_wdata,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 3'b010, 32'h10, 32'h8000_00FF, 5'd3, 0, got);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 5'd1, 0, got);
        chk("lb_const",  got, 32'hFFFF_FFFF);
        do_req(1'b0, 3'b100, 32'h10, 32'h0, 5'd2, 0, got);
        chk("lbu_const", got, 32'h0000_00FF);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 5'd3, 0, got);
        chk("lh_const",  got, 32'h0000_00FF);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd4, 0, got);
        chk("lhu_const", got, 32'h0000_00FF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0, got);
        chk("lw_const",  got, 32'h8000_00FF);

        do_req(1'b1, 3'b001, 32'h21, 32'hABCD, 5'd6, 0, got);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd7, 0, got);
        chk("lw_after_sh", got, {seed_byte(35), seed_byte(34), seed_byte(33), seed_byte(32)});

        do_req(1'b0, 3'b010, 32'(MSZ - 4), 32'h0, 5'd8, 0, got);
        do_req(1'b0, 3'b000, 32'(MSZ - 3), 32'h0, 5'd9, 0, got);
        do_req(1'b0, 3'b011, 32'h40, 32'h0, 5'd10, 0, got);
        do_req(1'b1, 3'b100, 32'h40, 32'h1234_5678, 5'd11, 0, got);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 5'd12, 5, got);
        do_req(1'b0, 3'b100, 32'h31, 32'h0, 5'd13, 0, got);

        // Reset lands in the middle of a store's access cycle.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h1234_5678;
        req_rd     = 5'd0;
        chk("rstw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 chk("rstw_strobe", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1 chk("rstw_drop", 32'(mem_write), 32'd0);
        chk("rstw_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_req_ready", 32'(req_ready), 32'd1);
        chk("rstw_rspv",      32'(rsp_valid), 32'd0);
        chk("rstw_mem", {mem[67], mem[66], mem[65], mem[64]},
            {ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]});
        @(negedge clk);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd14, 0, got);

        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom % 2);
            if ($urandom % 5 == 0)   f3 = 3'($urandom);
            else if (we)             f3 = 3'($urandom % 3);
            else                     f3 = lf3[$urandom % 5];
            case ($urandom % 4)
                0:       a = ($urandom % 256) & ~32'd3;
                1:       a = $urandom % 256;
                2:       a = 32'(MSZ - 8) + ($urandom % 8);
                default: a = ($urandom % 128) & ~32'd1;
            endcase
            do_req(we, f3, a, $urandom, 5'($urandom), int'($urandom % 3), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
